// File: rtl/drive_free_rx_fifo_pkg.sv
// rtl/drive_free_rx_fifo_pkg.sv - shared types and sizing helpers for the drive/free receiver
package drive_free_rx_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FULL_WAIT = 2'd1,
        ST_FREE      = 2'd2
    } rx_state_e;

    // Occupancy must represent 0..depth inclusive, hence one bit more than the pointers.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/drive_free_rx_fifo_if.sv
// rtl/drive_free_rx_fifo_if.sv - upstream drive/free handshake plus downstream valid/ready stream
interface drive_free_rx_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    logic                                               i_drive;
    logic [DATA_WIDTH-1:0]                              i_data;
    logic                                               o_free;
    logic                                               o_valid;
    logic [DATA_WIDTH-1:0]                              o_data;
    logic                                               i_ready;
    logic [drive_free_rx_fifo_pkg::count_width(DEPTH)-1:0] o_count;
    logic                                               o_overrun;

    modport master (
        output i_drive, i_data, i_ready,
        input  o_free, o_valid, o_data, o_count, o_overrun
    );

    modport slave (
        input  i_drive, i_data, i_ready,
        output o_free, o_valid, o_data, o_count, o_overrun
    );
endinterface

// File: rtl/drive_free_rx_fifo_fifo.sv
// rtl/drive_free_rx_fifo_fifo.sv - first-word-fall-through FIFO with registered head word
module rx_sync_fifo
    import drive_free_rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic                           pop,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic                           valid,
    output logic [count_width(DEPTH)-1:0]  count,
    output logic                           full,
    output logic                           empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [CW-1:0]         count_q;
    logic [DATA_WIDTH-1:0] head_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign count   = count_q;
    assign valid   = ~empty;
    assign rdata   = head_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // The head register only moves when a new word becomes the head, so it holds when empty.
            if (do_pop) begin
                if (count_q > CW'(1)) begin
                    head_q <= mem[rd_ptr + 1'b1];
                end else if (do_push) begin
                    head_q <= wdata;
                end
            end else if (empty && do_push) begin
                head_q <= wdata;
            end
        end
    end
endmodule

// File: rtl/drive_free_rx_fifo.sv
// rtl/drive_free_rx_fifo.sv - clocked receiver for the drive/free bundled-data handshake
module drive_free_rx_fifo
    import drive_free_rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FREE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    drive_free_rx_fifo_if.slave  bus
);
    localparam int CW  = count_width(DEPTH);
    localparam int FCW = $clog2(FREE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_vld_q;
    logic                   prev_q;
    logic                   armed_q;
    logic                   pending_q;
    logic                   overrun_q;
    logic                   free_q;
    logic [FCW-1:0]         free_cnt_q;
    rx_state_e              state_q;

    logic                   rise;
    logic                   push;
    logic                   pop_now;
    logic [DATA_WIDTH-1:0]  fifo_data;
    logic                   fifo_valid;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;

    rx_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (bus.i_data),
        .pop   (bus.i_ready),
        .rdata (fifo_data),
        .valid (fifo_valid),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A drive level already high when reset lifts is not a token; edges count only once a low was seen.
    assign rise    = armed_q & sync_q[SYNC_STAGES-1] & ~prev_q;
    assign pop_now = bus.i_ready & ~fifo_empty;
    assign push    = pending_q & (state_q != ST_FREE)
                   & (~fifo_full | ((state_q == ST_FULL_WAIT) & pop_now));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            sync_vld_q <= '0;
            prev_q     <= 1'b0;
            armed_q    <= 1'b0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            free_q     <= 1'b0;
            free_cnt_q <= '0;
            state_q    <= ST_IDLE;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.i_drive};
            sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
            prev_q     <= sync_q[SYNC_STAGES-1];
            if (sync_vld_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1]) begin
                armed_q <= 1'b1;
            end
            if (rise && pending_q) begin
                overrun_q <= 1'b1;
            end
            if (rise && !pending_q) begin
                pending_q <= 1'b1;
            end else if (push) begin
                pending_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE, ST_FULL_WAIT: begin
                    if (push) begin
                        free_q     <= 1'b1;
                        free_cnt_q <= FCW'(FREE_CYCLES - 1);
                        state_q    <= ST_FREE;
                    end else if (pending_q && fifo_full) begin
                        state_q <= ST_FULL_WAIT;
                    end
                end
                ST_FREE: begin
                    if (free_cnt_q == '0) begin
                        free_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        free_cnt_q <= free_cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_free    = free_q;
    assign bus.o_valid   = fifo_valid;
    assign bus.o_data    = fifo_data;
    assign bus.o_count   = fifo_count;
    assign bus.o_overrun = overrun_q;
endmodule

// File: tb/tb_drive_free_rx_fifo.sv
// tb/tb_drive_free_rx_fifo.sv - directed and randomized bench with a queue-based reference model
module tb_drive_free_rx_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int SS    = 2;
    localparam int FC    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    drive_free_rx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    drive_free_rx_fifo #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SS),
        .FREE_CYCLES (FC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] last_head;
    logic [DW-1:0] cur_data;
    bit          token_out;
    bit          pop_pend;
    bit          free_prev;
    int          free_w;
    int          max_cnt;
    bit          ready_val;
    bit          ready_rand;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: a word enters the queue when its free pulse starts, leaves when ready met valid.
    task automatic cycle();
        @(negedge clk);
        if (rst) begin
            q.delete();
            token_out = 0;
            pop_pend  = 0;
            free_prev = 0;
            free_w    = 0;
            last_head = '0;
        end else begin
            if (pop_pend) void'(q.pop_front());
            if (bus.o_free && !free_prev) begin
                chk("free_has_token", token_out, 1);
                if (token_out) q.push_back(cur_data);
                token_out = 0;
            end
            if (bus.o_free) free_w++;
            else if (free_prev) begin
                chk("free_width", free_w, FC);
                free_w = 0;
            end
            free_prev = bus.o_free;
            chk("count", bus.o_count, q.size());
            chk("valid", bus.o_valid, q.size() != 0);
            if (q.size() != 0) last_head = q[0];
            chk("data", bus.o_data, last_head);
            if (int'(bus.o_count) > max_cnt) max_cnt = int'(bus.o_count);
        end
        bus.i_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
        pop_pend = bus.i_ready && bus.o_valid && !rst;
    endtask

    task automatic send_token(input logic [DW-1:0] data, input int hi);
        cur_data    = data;
        token_out   = 1;
        bus.i_data  = data;
        bus.i_drive = 1'b1;
        repeat (hi) cycle();
        bus.i_drive = 1'b0;
        repeat (2) cycle();
    endtask

    task automatic wait_free(input int budget);
        int n = 0;
        while ((token_out || bus.o_free) && n < budget) begin
            cycle();
            n++;
        end
        chk("free_timeout", token_out || bus.o_free, 0);
    endtask

    initial begin
        int lat;
        bit seen;
        int n;
        rst = 1'b1;
        bus.i_drive = 1'b1;
        bus.i_data  = '0;
        bus.i_ready = 1'b0;
        ready_val = 0; ready_rand = 0; token_out = 0; pop_pend = 0;
        free_prev = 0; free_w = 0; max_cnt = 0; last_head = '0;

        repeat (3) cycle();
        chk("rst_free", bus.o_free, 0);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_count", bus.o_count, 0);
        chk("rst_data", bus.o_data, 0);
        chk("rst_overrun", bus.o_overrun, 0);
        rst = 1'b0;
        repeat (10) cycle();
        chk("held_drive_no_token", bus.o_count, 0);
        bus.i_drive = 1'b0;
        repeat (4) cycle();

        ready_val  = 1;
        cur_data   = 32'hA5A5_0001;
        token_out  = 1;
        bus.i_data = cur_data;
        bus.i_drive = 1'b1;
        lat = 0; seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) bus.i_drive = 1'b0;
            cycle();
            if (!seen && bus.o_valid) begin
                seen = 1;
                lat  = i + 1;
            end
        end
        chk("single_latency", (lat >= SS + 2) && (lat <= SS + 3), 1);
        chk("single_freed", token_out, 0);
        repeat (3) cycle();

        max_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            send_token($urandom, $urandom_range(2, 4));
            wait_free(40);
        end
        repeat (4) cycle();
        chk("wrap_max_count", max_cnt <= 1, 1);
        chk("wrap_no_overrun", bus.o_overrun, 0);
        chk("wrap_drained", bus.o_count, 0);

        ready_rand = 1;
        for (int i = 0; i < 8; i++) begin
            send_token($urandom, $urandom_range(2, 5));
            wait_free(200);
        end
        ready_rand = 0;
        ready_val  = 1;
        repeat (10) cycle();
        chk("rand_drained", bus.o_count, 0);

        ready_val = 0;
        for (int i = 1; i <= 4; i++) begin
            send_token(DW'(i), 2);
            wait_free(40);
        end
        chk("fill_count", bus.o_count, DEPTH);
        send_token(DW'(5), 2);
        repeat (8) cycle();
        chk("fullwait_free", bus.o_free, 0);
        chk("fullwait_count", bus.o_count, DEPTH);
        chk("fullwait_pending", token_out, 1);
        bus.i_drive = 1'b1;
        repeat (2) cycle();
        bus.i_drive = 1'b0;
        repeat (6) cycle();
        chk("overrun_set", bus.o_overrun, 1);
        ready_val = 1;
        cycle();
        ready_val = 0;
        repeat (6) cycle();
        chk("fullwait_pushed", token_out, 0);
        chk("push_pop_full_count", bus.o_count, DEPTH);
        ready_val = 1;
        repeat (8) cycle();
        chk("fill_drained", bus.o_count, 0);
        chk("overrun_sticky", bus.o_overrun, 1);

        send_token($urandom, 2);
        n = 0;
        while (!bus.o_free && n < 20) begin
            cycle();
            n++;
        end
        chk("midop_free_seen", bus.o_free, 1);
        rst = 1'b1;
        cycle();
        chk("midop_free", bus.o_free, 0);
        chk("midop_count", bus.o_count, 0);
        chk("midop_valid", bus.o_valid, 0);
        chk("midop_overrun", bus.o_overrun, 0);
        rst = 1'b0;
        repeat (6) cycle();
        chk("midop_no_late_free", bus.o_free, 0);
        send_token(32'h0BAD_CAFE, 3);
        wait_free(40);
        repeat (3) cycle();
        chk("post_reset_drained", bus.o_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
